seg595_scan_driver: RTL

Parametrised multi-digit seven-segment scan driver for a daisy-chained 74HC595 segment/digit shift-register pair. It snapshots a packed BCD/hex word, per-digit decimal-point and blank masks once per frame, then decodes digits internally. Each digit is shifted out as a {segment, one-hot digit select} word with its own serial clock and latch generation, so no separate 595 driver instance is needed. It sits between the clock/counter datapath and the board display pins.

---
 rtl/seg595_scan_driver.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg595_scan_driver.sv
// -----------------------------------------------------------------------------
// seg595_scan_driver
//
// Multiplexed seven-segment scan driver for a daisy-chained pair of 74HC595
// shift registers: one register drives the segments, the other the one-hot
// digit selects. At the start of each frame it snapshots the digit codes and
// the decimal-point and blank masks. It decodes each digit and shifts out the
// word {seg[7:0], sel[DIGITS-1:0]} MSB first. It generates the 595 shift clock
// and latch clock itself.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   enable      in   1: run frames back to back; 0: finish the current frame
//   data_in     in   packed 4-bit codes, digit i = data_in[4i+3:4i]
//   dp_in       in   decimal point per digit
//   blank_in    in   per-digit blank (all segments and dp off)
//   data_ser    out  serial data to 595 SER
//   srclk       out  595 shift clock
//   rclk        out  595 storage (latch) clock
//   busy        out  high from LOAD through the end of the last LATCH
//   frame_done  out  one-cycle pulse in the IDLE cycle after the last latch
// -----------------------------------------------------------------------------
module seg595_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 4,
  parameter bit HEX_EN         = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic                  data_ser,
  output logic                  srclk,
  output logic                  rclk,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int WORD_W = 8 + DIGITS;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WORD_W - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_LATCH} state_e;

  state_e              state_q, state_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  // SHIFT: phase 0 = srclk low half, 1 = srclk high half.
  // LATCH: phase 0 = rclk high, 1 = rclk low (settle before the next word).
  logic                phase_q, phase_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_blank_q, snap_blank_d;

  logic data_ser_q, data_ser_d;
  logic srclk_q, srclk_d;
  logic rclk_q, rclk_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  // Digit codes split out of the snapshot. The snapshot's next value is used,
  // so the first bit already comes from freshly loaded data.
  logic [3:0] code_arr [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_code
    assign code_arr[gi] = snap_data_d[4*gi +: 4];
  end

  // Active-high {g,f,e,d,c,b,a} pattern for one code.
  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    if (!HEX_EN && (code > 4'd9)) begin
      seg = 7'h00;
    end
    return seg;
  endfunction

  // State register (outputs are registered alongside the state).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      digit_q      <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      div_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      data_ser_q   <= 1'b0;
      srclk_q      <= 1'b0;
      rclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      data_ser_q   <= data_ser_d;
      srclk_q      <= srclk_d;
      rclk_q       <= rclk_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    div_d        = div_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        snap_data_d  = data_in;
        snap_dp_d    = dp_in;
        snap_blank_d = blank_in;
        digit_d      = '0;
        bit_d        = BIT_FIRST;
        phase_d      = 1'b0;
        div_d        = '0;
        state_d      = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          // End of a high half: move to the next bit or finish the word.
          if (phase_q) begin
            if (bit_q == '0) begin
              state_d = ST_LATCH;
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (digit_q == DIG_LAST) begin
              state_d = ST_IDLE;
            end else begin
              digit_d = digit_q + 1'b1;
              bit_d   = BIT_FIRST;
              state_d = ST_SHIFT;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. It is computed from the next state so the registered pins
  // line up with the state they belong to. There is no combinational path
  // from the inputs to the pins.
  logic [3:0]        code_sel;
  logic [7:0]        seg_word;
  logic [DIGITS-1:0] sel_word;
  logic [WORD_W-1:0] word;

  always_comb begin
    code_sel = code_arr[digit_d];
    seg_word = {snap_dp_d[digit_d], decode7(code_sel)};
    if (snap_blank_d[digit_d]) begin
      seg_word = 8'h00;
    end
    sel_word = DIGITS'(1) << digit_d;
    if (SEG_ACTIVE_LOW) begin
      seg_word = ~seg_word;
    end
    if (DIG_ACTIVE_LOW) begin
      sel_word = ~sel_word;
    end
    word = {seg_word, sel_word};

    // SER only moves at the start of a low half, so it is stable around
    // every srclk rising edge. Outside SHIFT it holds.
    data_ser_d = data_ser_q;
    if (state_d == ST_SHIFT) begin
      data_ser_d = word[bit_d];
    end
    srclk_d      = (state_d == ST_SHIFT) && phase_d;
    rclk_d       = (state_d == ST_LATCH) && !phase_d;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
  end

  assign data_ser   = data_ser_q;
  assign srclk      = srclk_q;
  assign rclk       = rclk_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
